// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: redirect/hazard controls, instruction-memory port and IF/ID outputs.
interface fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic        jump;
  logic        jr;
  logic [31:0] br_base;
  logic [15:0] br_offset;
  logic [25:0] jump_addr;
  logic [31:0] jr_target;
  logic [31:0] imem_pc;
  logic [31:0] imem_read;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus1;
  logic [31:0] if_id_instr;

  modport slave (
    input  stall, flush, branch_taken, jump, jr,
    input  br_base, br_offset, jump_addr, jr_target, imem_read,
    output imem_pc, if_id_valid, if_id_pc, if_id_pc_plus1, if_id_instr
  );

  modport master (
    output stall, flush, branch_taken, jump, jr,
    output br_base, br_offset, jump_addr, jr_target, imem_read,
    input  imem_pc, if_id_valid, if_id_pc, if_id_pc_plus1, if_id_instr
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: word-indexed PC, redirect/stall/flush handling, IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);
  localparam logic [1:0] S_RESET    = 2'd0;
  localparam logic [1:0] S_FETCH    = 2'd1;
  localparam logic [1:0] S_HOLD     = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_plus1;
  logic [31:0] target;
  logic        redirect;

  logic        valid_q;
  logic [31:0] id_pc_q, id_pc1_q, id_instr_q;

  assign pc_plus1 = pc_q + 32'd1;
  assign redirect = bus.jr | bus.jump | bus.branch_taken;

  // jr beats jump beats branch; all arithmetic wraps modulo 2^32
  always_comb begin
    target = bus.br_base + {{16{bus.br_offset[15]}}, bus.br_offset};
    if (bus.jr)        target = bus.jr_target;
    else if (bus.jump) target = {bus.br_base[31:26], bus.jump_addr};
  end

  always_comb begin
    state_d = state_q;
    if (redirect) state_d = S_REDIRECT;
    else begin
      case (state_q)
        S_RESET, S_REDIRECT, S_FETCH, S_HOLD:
          state_d = bus.stall ? S_HOLD : S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      id_pc_q    <= 32'd0;
      id_pc1_q   <= 32'd0;
      id_instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      if (redirect || bus.flush) begin
        // redirect overrides stall; a plain flush still honours it for the PC
        if (redirect)        pc_q <= target;
        else if (!bus.stall) pc_q <= pc_plus1;
        valid_q    <= 1'b0;
        id_pc_q    <= 32'd0;
        id_pc1_q   <= 32'd0;
        id_instr_q <= NOP_INSTR;
      end else if (!bus.stall) begin
        pc_q       <= pc_plus1;
        valid_q    <= 1'b1;
        id_pc_q    <= pc_q;
        id_pc1_q   <= pc_plus1;
        id_instr_q <= bus.imem_read;
      end
    end
  end

  assign bus.imem_pc        = pc_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.if_id_pc       = id_pc_q;
  assign bus.if_id_pc_plus1 = id_pc1_q;
  assign bus.if_id_instr    = id_instr_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory model returns word index + 0x100.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_read = bus.imem_pc + 32'h100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.flush = 0; bus.branch_taken = 0; bus.jump = 0; bus.jr = 0;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] pc1, input logic [31:0] instr);
    chk({tag, ".valid"}, {31'd0, bus.if_id_valid}, {31'd0, v});
    chk({tag, ".pc"},    bus.if_id_pc,       pc);
    chk({tag, ".pc1"},   bus.if_id_pc_plus1, pc1);
    chk({tag, ".instr"}, bus.if_id_instr,    instr);
  endtask

  initial begin
    idle();
    bus.br_base = 0; bus.br_offset = 0; bus.jump_addr = 0; bus.jr_target = 0;
    rst = 1;
    step(); step();
    chk("rst.imem_pc", bus.imem_pc, 32'h0);
    chk_ifid("rst", 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 0;

    // sequential fetch
    step();
    chk_ifid("seq0", 1'b1, 32'd0, 32'd1, 32'h100);
    chk("seq0.imem_pc", bus.imem_pc, 32'd1);
    step(); step(); step();
    chk_ifid("seq3", 1'b1, 32'd3, 32'd4, 32'h103);
    step();
    chk("seq4.imem_pc", bus.imem_pc, 32'd5);

    // stall at pc 5
    bus.stall = 1;
    step(); step(); step();
    chk("stall.imem_pc", bus.imem_pc, 32'd5);
    chk_ifid("stall", 1'b1, 32'd4, 32'd5, 32'h104);
    bus.stall = 0;
    step();
    chk("resume5.pc", bus.if_id_pc, 32'd5);
    step();
    chk("resume6.pc", bus.if_id_pc, 32'd6);
    chk("resume6.imem_pc", bus.imem_pc, 32'd7);

    // backward branch 10 + (-4) = 6
    bus.branch_taken = 1; bus.br_base = 32'd10; bus.br_offset = 16'hFFFC;
    step();
    chk("br.imem_pc", bus.imem_pc, 32'd6);
    chk_ifid("br.bubble", 1'b0, 32'd0, 32'd0, 32'h0);
    idle();
    step();
    chk_ifid("br.fetch", 1'b1, 32'd6, 32'd7, 32'h106);

    // jr wins over jump and branch
    bus.jr = 1; bus.jump = 1; bus.branch_taken = 1;
    bus.jr_target = 32'h40; bus.jump_addr = 26'h5; bus.br_offset = 16'h1;
    step();
    chk("jr.imem_pc", bus.imem_pc, 32'h40);
    chk("jr.valid", {31'd0, bus.if_id_valid}, 32'd0);
    idle();
    step();
    chk_ifid("jr.fetch", 1'b1, 32'h40, 32'h41, 32'h140);

    // jump beats stall
    bus.stall = 1; bus.jump = 1; bus.br_base = 32'hF000_0000; bus.jump_addr = 26'h20;
    step();
    chk("jmp.imem_pc", bus.imem_pc, 32'hF000_0020);
    chk_ifid("jmp.bubble", 1'b0, 32'd0, 32'd0, 32'h0);
    bus.jump = 0;
    step();
    chk("jmp.hold", bus.imem_pc, 32'hF000_0020);
    bus.stall = 0;
    step();
    chk_ifid("jmp.fetch", 1'b1, 32'hF000_0020, 32'hF000_0021, 32'hF000_0120);

    // flush advances pc; flush with stall holds pc
    bus.flush = 1;
    step();
    chk("fl.imem_pc", bus.imem_pc, 32'hF000_0022);
    chk_ifid("fl.bubble", 1'b0, 32'd0, 32'd0, 32'h0);
    bus.stall = 1;
    step();
    chk("flst.imem_pc", bus.imem_pc, 32'hF000_0022);
    idle();

    // PC wrap
    bus.jr = 1; bus.jr_target = 32'hFFFF_FFFF;
    step();
    chk("wrap.imem_pc", bus.imem_pc, 32'hFFFF_FFFF);
    idle();
    step();
    chk("wrap.imem_pc0", bus.imem_pc, 32'h0);
    chk_ifid("wrap", 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0000_00FF);
    step();
    chk("wrap.next", bus.if_id_pc, 32'h0);

    // reset during stall
    bus.stall = 1;
    step();
    rst = 1;
    step();
    chk("rststall.imem_pc", bus.imem_pc, 32'h0);
    chk("rststall.valid", {31'd0, bus.if_id_valid}, 32'd0);
    // reset with redirect asserted
    bus.stall = 0; bus.jr = 1; bus.jr_target = 32'h77;
    step();
    chk("rstjr.imem_pc", bus.imem_pc, 32'h0);
    chk_ifid("rstjr", 1'b0, 32'd0, 32'd0, 32'h0);
    idle();
    rst = 0;
    step();
    chk_ifid("postrst", 1'b1, 32'd0, 32'd1, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
